// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - cache-to-memory block request interface
interface data_memory_responder_if #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
);
    logic                   mem_read;
    logic                   mem_write;
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic [BLOCK_WIDTH-1:0] mem_writedata;
    logic [BLOCK_WIDTH-1:0] mem_readdata;
    logic                   mem_busywait;

    // cache side
    modport master (
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    // memory side
    modport slave (
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - fixed-latency block memory responder; optional DATA_MEMORY_ACCESS_COUNTERS_EN
module data_memory_responder #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128,
    parameter int DEPTH_LOG2  = 8,
    parameter int LATENCY     = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    data_memory_responder_if.slave  mem_if
`ifdef DATA_MEMORY_ACCESS_COUNTERS_EN
    ,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Request cycle counts as the first busy cycle, so BUSY lasts LATENCY-1 cycles.
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 2);

    logic [BLOCK_WIDTH-1:0] r_mem [0:(2**DEPTH_LOG2)-1];

    state_t                 r_state;
    logic [7:0]             r_cnt;
    logic                   r_op_write;
    logic [DEPTH_LOG2-1:0]  r_idx;
    logic [BLOCK_WIDTH-1:0] r_wdata;
    logic [BLOCK_WIDTH-1:0] r_readdata;

    logic                   w_req;
    logic                   w_commit;
    logic                   w_unused_addr;

    assign w_req    = mem_if.mem_read | mem_if.mem_write;
    assign w_commit = (r_state == ST_BUSY) && (r_cnt == 8'd0);

    // Upper address bits alias onto the stored range.
    assign w_unused_addr = ^mem_if.mem_address[ADDR_WIDTH-1:DEPTH_LOG2];

    // Busywait rises combinationally in the request cycle so the cache stalls at once.
    assign mem_if.mem_busywait = !reset &&
                                 (((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY));
    assign mem_if.mem_readdata = r_readdata;

    // Access sequencer: latch request, count down latency, commit, one DONE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_op_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_readdata <= '0;
`ifdef DATA_MEMORY_ACCESS_COUNTERS_EN
            read_count  <= 32'd0;
            write_count <= 32'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        // A simultaneous read and write is handled as a write.
                        r_op_write <= mem_if.mem_write;
                        r_idx      <= mem_if.mem_address[DEPTH_LOG2-1:0];
                        r_wdata    <= mem_if.mem_writedata;
                        r_cnt      <= CNT_INIT;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd0) begin
                        if (!r_op_write) begin
                            r_readdata <= r_mem[r_idx];
                        end
`ifdef DATA_MEMORY_ACCESS_COUNTERS_EN
                        if (r_op_write) begin
                            write_count <= write_count + 32'd1;
                        end else begin
                            read_count <= read_count + 32'd1;
                        end
`endif
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requests still held here belong to the finished access.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Block store; a reset during BUSY suppresses the commit.
    always_ff @(posedge clock) begin
        if (!reset && w_commit && r_op_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed self-checking bench for data_memory_responder
module tb_data_memory_responder;

    localparam int AW = 28;
    localparam int BW = 128;

    logic clock;
    logic reset;

    int n_cmp;
    int n_err;
    int exp_rd;
    int exp_wr;

    data_memory_responder_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) mem_if ();

`ifdef DATA_MEMORY_ACCESS_COUNTERS_EN
    logic [31:0] read_count;
    logic [31:0] write_count;
`endif

    data_memory_responder #(
        .ADDR_WIDTH  (AW),
        .BLOCK_WIDTH (BW),
        .DEPTH_LOG2  (8),
        .LATENCY     (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_if      (mem_if)
`ifdef DATA_MEMORY_ACCESS_COUNTERS_EN
        ,
        .read_count  (read_count),
        .write_count (write_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cache-style access: hold the request until busywait falls, optionally
    // disturbing address/data once busy_cycles reaches chg_at.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [AW-1:0] addr, input logic [BW-1:0] data,
                             input int chg_at, input logic [AW-1:0] chg_addr,
                             input logic [BW-1:0] chg_data,
                             output int busy, output logic [BW-1:0] rdata);
        logic done;
        done  = 1'b0;
        busy  = 0;
        rdata = '0;
        @(posedge clock); #1;
        mem_if.mem_read      = rd;
        mem_if.mem_write     = wr;
        mem_if.mem_address   = addr;
        mem_if.mem_writedata = data;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (mem_if.mem_busywait) begin
                busy++;
                if (busy == chg_at) begin
                    mem_if.mem_address   = chg_addr;
                    mem_if.mem_writedata = chg_data;
                end
            end else begin
                done  = 1'b1;
                rdata = mem_if.mem_readdata;
            end
        end
        check_eq("access_done", BW'(done), BW'(1));
        @(posedge clock); #1;
        mem_if.mem_read  = 1'b0;
        mem_if.mem_write = 1'b0;
        if (done) begin
            if (wr) exp_wr++;
            else if (rd) exp_rd++;
        end
    endtask

    localparam logic [BW-1:0] D1  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [BW-1:0] D7  = 128'h7777_7777_0707_0707_7070_7070_7777_0007;
    localparam logic [BW-1:0] D8  = 128'h8888_8888_0808_0808_8080_8080_8888_0008;
    localparam logic [BW-1:0] DX  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [BW-1:0] D9  = 128'h9999_0000_9999_0000_1234_5678_9ABC_DEF0;
    localparam logic [BW-1:0] DF  = 128'hFEED_FACE_CAFE_F00D_0BAD_C0DE_FACE_0255;
    localparam logic [BW-1:0] DA  = 128'hA5A5_5A5A_0A0A_A0A0_1111_2222_3333_4444;

    int busy;
    logic [BW-1:0] rdata;

    initial begin
        n_cmp = 0; n_err = 0; exp_rd = 0; exp_wr = 0;
        reset = 1'b1;
        mem_if.mem_read      = 1'b0;
        mem_if.mem_write     = 1'b0;
        mem_if.mem_address   = '0;
        mem_if.mem_writedata = '0;

        // Reset: busywait held low even with a request present.
        @(negedge clock);
        check_eq("rst_busy_c1", BW'(mem_if.mem_busywait), BW'(0));
        check_eq("rst_rdata_c1", mem_if.mem_readdata, '0);
        @(posedge clock); #1;
        mem_if.mem_read = 1'b1;
        @(negedge clock);
        check_eq("rst_busy_c2_req", BW'(mem_if.mem_busywait), BW'(0));
        check_eq("rst_rdata_c2", mem_if.mem_readdata, '0);
        @(posedge clock); #1;
        reset = 1'b0;
        mem_if.mem_read = 1'b0;
        @(negedge clock);
        check_eq("idle_busy", BW'(mem_if.mem_busywait), BW'(0));
        check_eq("idle_rdata", mem_if.mem_readdata, '0);

        // Write then read 0x05.
        do_access(1'b0, 1'b1, 28'h005, D1, 0, '0, '0, busy, rdata);
        check_eq("wr05_busy", BW'(busy), BW'(5));
        check_eq("wr05_rdata_hold", rdata, '0);
        do_access(1'b1, 1'b0, 28'h005, '0, 0, '0, '0, busy, rdata);
        check_eq("rd05_busy", BW'(busy), BW'(5));
        check_eq("rd05_data", rdata, D1);

        // Alias: 0x105 maps to index 0x05.
        do_access(1'b1, 1'b0, 28'h105, '0, 0, '0, '0, busy, rdata);
        check_eq("rd105_busy", BW'(busy), BW'(5));
        check_eq("rd105_data", rdata, D1);

        // Inputs changed during BUSY must not affect the latched write.
        do_access(1'b0, 1'b1, 28'h008, D8, 0, '0, '0, busy, rdata);
        do_access(1'b0, 1'b1, 28'h007, D7, 4, 28'h008, DX, busy, rdata);
        check_eq("wr07_busy", BW'(busy), BW'(5));
        do_access(1'b1, 1'b0, 28'h007, '0, 0, '0, '0, busy, rdata);
        check_eq("rd07_data", rdata, D7);
        do_access(1'b1, 1'b0, 28'h008, '0, 0, '0, '0, busy, rdata);
        check_eq("rd08_data", rdata, D8);

        // Reset in BUSY cycle 2 aborts the write to 0x09.
        do_access(1'b0, 1'b1, 28'h009, D9, 0, '0, '0, busy, rdata);
        @(posedge clock); #1;
        mem_if.mem_write     = 1'b1;
        mem_if.mem_address   = 28'h009;
        mem_if.mem_writedata = {BW{1'b1}};
        @(negedge clock);
        check_eq("abort_req_busy", BW'(mem_if.mem_busywait), BW'(1));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        mem_if.mem_write = 1'b0;
        @(negedge clock);
        check_eq("abort_rst_busy", BW'(mem_if.mem_busywait), BW'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("abort_post_busy", BW'(mem_if.mem_busywait), BW'(0));
        check_eq("abort_post_rdata", mem_if.mem_readdata, '0);
        do_access(1'b1, 1'b0, 28'h009, '0, 0, '0, '0, busy, rdata);
        check_eq("rd09_busy", BW'(busy), BW'(5));
        check_eq("rd09_data", rdata, D9);

        // Top index 255, read back through alias 0x1FF.
        do_access(1'b0, 1'b1, 28'h0FF, DF, 0, '0, '0, busy, rdata);
        do_access(1'b1, 1'b0, 28'h1FF, '0, 0, '0, '0, busy, rdata);
        check_eq("rd1ff_data", rdata, DF);

        // Read and write together act as a write; readdata keeps the last read.
        do_access(1'b1, 1'b1, 28'h00A, DA, 0, '0, '0, busy, rdata);
        check_eq("both_busy", BW'(busy), BW'(5));
        check_eq("both_rdata_hold", rdata, DF);
        do_access(1'b1, 1'b0, 28'h00A, '0, 0, '0, '0, busy, rdata);
        check_eq("rd0a_data", rdata, DA);

`ifdef DATA_MEMORY_ACCESS_COUNTERS_EN
        @(negedge clock);
        check_eq("write_count", BW'(write_count), BW'(exp_wr));
        check_eq("read_count", BW'(read_count), BW'(exp_rd));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
